// File: rtl/video_scanout.sv
// Video timing generator and pixel sink for the scan-out path.
// Presents positions to the controller and aligns returned pixels with DE/sync.
module video_scanout #(
    parameter int H_ACTIVE   = 720,
    parameter int H_FP       = 12,
    parameter int H_SYNC     = 64,
    parameter int H_BP       = 68,
    parameter int V_ACTIVE   = 720,
    parameter int V_FP       = 5,
    parameter int V_SYNC     = 5,
    parameter int V_BP       = 20,
    parameter int PIPE_DELAY = 3,
    parameter bit HSYNC_POL  = 1'b1,
    parameter bit VSYNC_POL  = 1'b1
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_enable,
    output logic        o_video_hblank,
    output logic        o_video_vblank,
    output logic [10:0] o_video_pos_x,
    output logic [10:0] o_video_pos_y,
    input  logic [31:0] i_video_rdata,
    output logic [23:0] o_rgb,
    output logic        o_de,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_frame_start,
    output logic [31:0] o_frame_counter
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CW = 16;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] h_count;
    logic [CW-1:0] v_count;
    logic [CW-1:0] h_next;
    logic [CW-1:0] v_next;
    logic          running;

    logic de_raw;
    logic hs_raw;
    logic vs_raw;

    logic [PIPE_DELAY-1:0] de_pipe;
    logic [PIPE_DELAY-1:0] hs_pipe;
    logic [PIPE_DELAY-1:0] vs_pipe;

    logic de_d;
    logic hs_d;
    logic vs_d;

    logic unused_rdata;

    // An idle generator (after reset or disable) restarts at (0,0).
    always_comb begin
        h_next = '0;
        v_next = '0;
        if (running) begin
            if (h_count == H_LAST) begin
                h_next = '0;
                v_next = (v_count == V_LAST) ? '0 : v_count + CW'(1);
            end else begin
                h_next = h_count + CW'(1);
                v_next = v_count;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            h_count         <= '0;
            v_count         <= '0;
            running         <= 1'b0;
            o_video_hblank  <= 1'b0;
            o_video_vblank  <= 1'b0;
            o_frame_start   <= 1'b0;
            o_frame_counter <= '0;
        end else if (!i_enable) begin
            h_count         <= '0;
            v_count         <= '0;
            running         <= 1'b0;
            o_video_hblank  <= 1'b1;
            o_video_vblank  <= 1'b1;
            o_frame_start   <= 1'b0;
        end else begin
            h_count        <= h_next;
            v_count        <= v_next;
            running        <= 1'b1;
            o_video_hblank <= (h_next >= H_ACT);
            o_video_vblank <= (v_next >= V_ACT);
            o_frame_start  <= (h_next == '0) && (v_next == '0);
            if (running && h_next == '0 && v_next == V_ACT) begin
                o_frame_counter <= o_frame_counter + 32'd1;
            end
        end
    end

    assign o_video_pos_x = h_count[10:0];
    assign o_video_pos_y = v_count[10:0];

    assign de_raw = running && (h_count < H_ACT) && (v_count < V_ACT);
    assign hs_raw = running && (h_count >= HS_BEG) && (h_count < HS_END);
    assign vs_raw = running && (v_count >= VS_BEG) && (v_count < VS_END);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            de_pipe <= '0;
            hs_pipe <= '0;
            vs_pipe <= '0;
        end else if (!i_enable) begin
            de_pipe <= '0;
            hs_pipe <= '0;
            vs_pipe <= '0;
        end else begin
            de_pipe[0] <= de_raw;
            hs_pipe[0] <= hs_raw;
            vs_pipe[0] <= vs_raw;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                de_pipe[i] <= de_pipe[i-1];
                hs_pipe[i] <= hs_pipe[i-1];
                vs_pipe[i] <= vs_pipe[i-1];
            end
        end
    end

    assign de_d = de_pipe[PIPE_DELAY-1];
    assign hs_d = hs_pipe[PIPE_DELAY-1];
    assign vs_d = vs_pipe[PIPE_DELAY-1];

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_rgb   <= '0;
            o_de    <= 1'b0;
            o_hsync <= ~HSYNC_POL;
            o_vsync <= ~VSYNC_POL;
        end else if (!i_enable) begin
            o_rgb   <= '0;
            o_de    <= 1'b0;
            o_hsync <= ~HSYNC_POL;
            o_vsync <= ~VSYNC_POL;
        end else begin
            o_rgb   <= de_d ? i_video_rdata[23:0] : 24'h0;
            o_de    <= de_d;
            o_hsync <= hs_d ~^ HSYNC_POL;
            o_vsync <= vs_d ~^ VSYNC_POL;
        end
    end

    // The pad byte of the pixel word carries nothing for the display.
    assign unused_rdata = ^i_video_rdata[31:24];

endmodule
